// File: rtl/calculate_k_and_error.sv
// calculate_k_and_error: one Levinson-Durbin step in float32.
//   k_(m+1) = -alpha_m / E_m,  E_(m+1) = E_m * (1 - k_(m+1)^2)
// Iterative 26-step restoring divider, then one shared truncating multiplier
// (used for k*k and for E*(1-k^2)) and a 1-x subtractor. All operations round
// toward zero and flush subnormals to +0.
// Optional feature: define CKAE_DIVZERO_FLAG_EN to add the oDivZero output.
module calculate_k_and_error #(
  parameter int unsigned LATENCY = 32
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iEnable,
  input  logic [31:0] iAlpham,
  input  logic [31:0] iErrorm,
  output logic [31:0] oKmp1,
  output logic [31:0] oErrormp1,
`ifdef CKAE_DIVZERO_FLAG_EN
  output logic        oDivZero,
`endif
  output logic        oDone
);

  // The datapath needs 30 edges (26 divide steps, normalise, square, subtract,
  // multiply); a smaller LATENCY is clamped to that floor.
  localparam logic [15:0] LAT_C = (LATENCY < 32'd30) ? 16'd30 : 16'(LATENCY);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DIV  = 3'd1,
    ST_SQ   = 3'd2,
    ST_SUB  = 3'd3,
    ST_MUL  = 3'd4,
    ST_WAIT = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  state_t      state_r;
  logic [15:0] cnt_r;       // index of the upcoming edge, counted from the start edge
  logic [4:0]  it_r;        // divide iterations completed
  logic [24:0] rem_r;       // partial remainder
  logic [25:0] quo_r;       // quotient bits, MSB is the integer bit
  logic [8:0]  alpha_se_r;  // alpha sign and exponent (mantissa only seeds rem_r)
  logic [31:0] err_r;
  logic [31:0] k_r;
  logic [30:0] sq_r;        // k*k, always non-negative
  logic [31:0] om_r;        // 1 - k*k
  logic [31:0] e_r;
`ifndef CKAE_DIVZERO_FLAG_EN
  logic        div_zero_r;
`endif

  logic [24:0] me_s;
  logic        div_ge_s;
  logic [24:0] rem_nxt_s;
  logic [31:0] mul_a_s;
  logic [31:0] mul_b_s;
  logic [31:0] mul_res_s;
  logic [31:0] k_nxt_s;
  logic [31:0] om_nxt_s;

  // Truncating float32 multiply; zero/subnormal operands or underflow give +0,
  // overflow gives the largest finite magnitude (toward zero).
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [47:0] prod;
    logic [9:0]  esum;
    logic [22:0] frac;
    logic [31:0] res;
    sgn  = a[31] ^ b[31];
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    esum = {2'b00, a[30:23]} + {2'b00, b[30:23]} + {9'd0, prod[47]};
    frac = 23'((prod[47] ? prod : (prod << 1)) >> 24);
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || esum <= 10'd127) begin
      res = 32'h0000_0000;
    end else if (esum >= 10'd382) begin
      res = {sgn, 31'h7F7F_FFFF};
    end else begin
      res = {sgn, 8'(esum - 10'd127), frac};
    end
    return res;
  endfunction

  // Pack the divider quotient into -alpha/E; a zero numerator or divisor gives +0.
  function automatic logic [31:0] fdiv_norm(input logic [8:0] a_se, input logic [8:0] e_se,
                                            input logic [25:0] quo);
    logic        sgn;
    logic [9:0]  top;
    logic [9:0]  bot;
    logic [22:0] frac;
    logic [31:0] res;
    sgn  = ~(a_se[8] ^ e_se[8]);
    top  = {2'b00, a_se[7:0]} + 10'd126 + {9'd0, quo[25]};
    bot  = {2'b00, e_se[7:0]};
    frac = 23'((quo[25] ? quo : (quo << 1)) >> 2);
    if (a_se[7:0] == 8'd0 || e_se[7:0] == 8'd0 || top <= bot) begin
      res = 32'h0000_0000;
    end else if (top >= bot + 10'd255) begin
      res = {sgn, 31'h7F7F_FFFF};
    end else begin
      res = {sgn, 8'(top - bot), frac};
    end
    return res;
  endfunction

  // 1.0 - x for non-negative x, exact in a 48-fraction-bit fixed-point window,
  // then truncated. Tiny x gives the float just below 1.0; huge x returns -x.
  function automatic logic [31:0] one_minus(input logic [30:0] x);
    logic [71:0] one_fx;
    logic [71:0] x_fx;
    logic [71:0] diff;
    logic [71:0] norm;
    logic        sgn;
    int          msb;
    logic [31:0] res;
    one_fx = 72'd1 << 48;
    x_fx   = 72'd0;
    diff   = 72'd0;
    norm   = 72'd0;
    sgn    = 1'b0;
    msb    = 0;
    if (x[30:23] == 8'd0) begin
      res = 32'h3F80_0000;
    end else if (x[30:23] < 8'd102) begin
      res = 32'h3F7F_FFFF;
    end else if (x[30:23] > 8'd150) begin
      res = {1'b1, x};
    end else begin
      x_fx = 72'({1'b1, x[22:0]}) << (x[30:23] - 8'd102);
      if (x_fx == one_fx) begin
        res = 32'h0000_0000;
      end else begin
        if (x_fx < one_fx) begin
          sgn  = 1'b0;
          diff = one_fx - x_fx;
        end else begin
          sgn  = 1'b1;
          diff = x_fx - one_fx;
        end
        for (int i = 0; i < 72; i++) begin
          if (diff[i]) msb = i;
          else         msb = msb;
        end
        // Any non-zero difference is at least 2^-24, so msb >= 24 here.
        norm = diff >> (msb - 23);
        res  = {sgn, 8'(msb + 79), 23'(norm)};
      end
    end
    return res;
  endfunction

  // Divider step, shared multiplier operand select and result packing.
  always_comb begin
    me_s      = {2'b01, err_r[22:0]};
    div_ge_s  = (rem_r >= me_s);
    rem_nxt_s = div_ge_s ? ((rem_r - me_s) << 1) : (rem_r << 1);
    mul_a_s   = (state_r == ST_SQ) ? k_r : err_r;
    mul_b_s   = (state_r == ST_SQ) ? k_r : om_r;
    mul_res_s = fmul(mul_a_s, mul_b_s);
    k_nxt_s   = fdiv_norm(alpha_se_r, err_r[31:23], quo_r);
    om_nxt_s  = one_minus(sq_r);
  end

`ifndef CKAE_DIVZERO_FLAG_EN
  // Without the flag port the divide-by-zero indication has no consumer; tie it off.
  always_comb begin
    div_zero_r = 1'b0;
  end
`define CKAE_DZ div_zero_r
`else
`define CKAE_DZ oDivZero
`endif

  // Control FSM with registered outputs; reset and a dropped iEnable abort.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 16'd0;
      it_r       <= 5'd0;
      rem_r      <= 25'd0;
      quo_r      <= 26'd0;
      alpha_se_r <= 9'd0;
      err_r      <= 32'h0;
      k_r        <= 32'h0;
      sq_r       <= 31'h0;
      om_r       <= 32'h0;
      e_r        <= 32'h0;
      oKmp1      <= 32'h0;
      oErrormp1  <= 32'h0;
      oDone      <= 1'b0;
`ifdef CKAE_DIVZERO_FLAG_EN
      oDivZero   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          oDone <= 1'b0;
`ifdef CKAE_DIVZERO_FLAG_EN
          oDivZero <= 1'b0;
`endif
          if (iEnable) begin
            alpha_se_r <= iAlpham[31:23];
            err_r      <= iErrorm;
            rem_r      <= {2'b01, iAlpham[22:0]};
            quo_r      <= 26'd0;
            it_r       <= 5'd0;
            cnt_r      <= 16'd1;
            state_r    <= ST_DIV;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DIV: begin
          if (!iEnable) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
            if (it_r != 5'd26) begin
              rem_r <= rem_nxt_s;
              quo_r <= {quo_r[24:0], div_ge_s};
              it_r  <= it_r + 5'd1;
            end else begin
              k_r     <= k_nxt_s;
              state_r <= ST_SQ;
            end
          end
        end
        ST_SQ: begin
          if (!iEnable) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r   <= cnt_r + 16'd1;
            sq_r    <= mul_res_s[30:0];
            state_r <= ST_SUB;
          end
        end
        ST_SUB: begin
          if (!iEnable) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r   <= cnt_r + 16'd1;
            om_r    <= om_nxt_s;
            state_r <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (!iEnable) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
            e_r   <= mul_res_s;
            if (cnt_r >= LAT_C) begin
              oKmp1     <= k_r;
              oErrormp1 <= mul_res_s;
              oDone     <= 1'b1;
`ifdef CKAE_DIVZERO_FLAG_EN
              oDivZero  <= (err_r[30:23] == 8'd0);
`endif
              state_r   <= ST_DONE;
            end else begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!iEnable) begin
            state_r <= ST_IDLE;
          end else if (cnt_r >= LAT_C) begin
            oKmp1     <= k_r;
            oErrormp1 <= e_r;
            oDone     <= 1'b1;
`ifdef CKAE_DIVZERO_FLAG_EN
            oDivZero  <= (err_r[30:23] == 8'd0);
`endif
            state_r   <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_DONE: begin
          if (!iEnable) begin
            oDone   <= 1'b0;
`ifdef CKAE_DIVZERO_FLAG_EN
            oDivZero <= 1'b0;
`endif
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          oDone   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`undef CKAE_DZ

endmodule

// File: tb/tb_calculate_k_and_error.sv
// Scoreboard bench for calculate_k_and_error: the driver pushes the expected
// result per operation, a negedge monitor pops it when oDone rises and checks
// latency, k, E and (when built with CKAE_DIVZERO_FLAG_EN) oDivZero.
module tb_calculate_k_and_error;

  localparam int unsigned LAT = 32;

  logic        clk = 1'b0;
  logic        iReset;
  logic        iEnable;
  logic [31:0] iAlpham;
  logic [31:0] iErrorm;
  logic [31:0] oKmp1;
  logic [31:0] oErrormp1;
  logic        oDone;
`ifdef CKAE_DIVZERO_FLAG_EN
  logic        oDivZero;
`endif

  calculate_k_and_error #(.LATENCY(LAT)) dut (
    .iClock    (clk),
    .iReset    (iReset),
    .iEnable   (iEnable),
    .iAlpham   (iAlpham),
    .iErrorm   (iErrorm),
    .oKmp1     (oKmp1),
    .oErrormp1 (oErrormp1),
`ifdef CKAE_DIVZERO_FLAG_EN
    .oDivZero  (oDivZero),
`endif
    .oDone     (oDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] k;
    logic [31:0] e;
    int unsigned tol;
    int unsigned start;
    logic        dz;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_x;
  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  logic        done_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit close(input logic [31:0] a, input logic [31:0] b, input int unsigned tol);
    logic [31:0] d;
    if (tol == 0) return (a === b);
    if (a[31] !== b[31]) return 1'b0;
    d = (a > b) ? (a - b) : (b - a);
    return (d <= tol);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req,
                     input int unsigned tol);
    n_vec++;
    if (!close(act, req, tol)) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (tol %0d ulp) at cycle %0d", name, act, req, tol, cyc);
    end
  endtask

  // Monitor: on each rising oDone pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (oDone === 1'b1 && done_d === 1'b0) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: oDone rose with no operation pending at cycle %0d", cyc);
      end else begin
        mon_x = sb_q.pop_front();
        chk("latency", 32'(cyc - mon_x.start), 32'(LAT), 0);
        chk("kmp1", oKmp1, mon_x.k, mon_x.tol);
        chk("errormp1", oErrormp1, mon_x.e, mon_x.tol);
`ifdef CKAE_DIVZERO_FLAG_EN
        chk("divzero", {31'd0, oDivZero}, {31'd0, mon_x.dz}, 0);
`endif
      end
    end
    done_d = oDone;
  end

  // Start one operation, scramble inputs after the start edge, wait for oDone
  // (bounded), then confirm the result holds while iEnable stays high.
  task automatic run_op(input logic [31:0] a, input logic [31:0] e, input logic [31:0] xk,
                        input logic [31:0] xe, input int unsigned tol, input logic dz);
    exp_t x;
    @(negedge clk);
    iAlpham = a;
    iErrorm = e;
    iEnable = 1'b1;
    x.k = xk; x.e = xe; x.tol = tol; x.start = cyc + 1; x.dz = dz;
    sb_q.push_back(x);
    @(negedge clk);
    iAlpham = 32'h4049_0FDB;
    iErrorm = 32'h4120_0000;
    for (int i = 0; i < 60 && oDone !== 1'b1; i++) @(negedge clk);
    if (oDone !== 1'b1) begin
      chk("done_timeout", {31'd0, oDone}, 32'd1, 0);
    end else begin
      repeat (3) begin
        @(negedge clk);
        chk("hold_done", {31'd0, oDone}, 32'd1, 0);
        chk("hold_k", oKmp1, xk, tol);
        chk("hold_e", oErrormp1, xe, tol);
      end
    end
  endtask

  // Drop iEnable from DONE: oDone clears at the next edge, data outputs persist.
  task automatic drop_en(input logic [31:0] xk, input logic [31:0] xe, input int unsigned tol);
    @(negedge clk);
    iEnable = 1'b0;
    @(negedge clk);
    chk("done_clear", {31'd0, oDone}, 32'd0, 0);
    chk("keep_k", oKmp1, xk, tol);
    chk("keep_e", oErrormp1, xe, tol);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    iReset  = 1'b0;
    iEnable = 1'b1;
    iAlpham = 32'h3F80_0000;
    iErrorm = 32'h3F80_0000;
    // Reset dominates iEnable.
    repeat (3) begin
      @(negedge clk);
      chk("rst_done", {31'd0, oDone}, 32'd0, 0);
      chk("rst_k", oKmp1, 32'h0, 0);
      chk("rst_e", oErrormp1, 32'h0, 0);
    end
    iReset  = 1'b1;
    iEnable = 1'b0;
    @(negedge clk);

    // 0.02 / 0.9 : approximate case.
    run_op(32'h3CA3_D70A, 32'h3F66_6666, 32'hBCB6_0B60, 32'h3F66_4945, 2, 1'b0);
    drop_en(32'hBCB6_0B60, 32'h3F66_4945, 2);

    // Exact cases.
    run_op(32'hBF00_0000, 32'h3F80_0000, 32'h3F00_0000, 32'h3F40_0000, 0, 1'b0);
    drop_en(32'h3F00_0000, 32'h3F40_0000, 0);
    run_op(32'h3E80_0000, 32'h3F00_0000, 32'hBF00_0000, 32'h3EC0_0000, 0, 1'b0);
    drop_en(32'hBF00_0000, 32'h3EC0_0000, 0);
    run_op(32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 0, 1'b0);
    drop_en(32'h0000_0000, 32'h3F80_0000, 0);

    // Reset ten edges into an operation: abort, outputs zeroed, no result.
    @(negedge clk);
    iAlpham = 32'hBF00_0000;
    iErrorm = 32'h3F80_0000;
    iEnable = 1'b1;
    repeat (10) @(negedge clk);
    iReset = 1'b0;
    @(negedge clk);
    chk("rstabort_done", {31'd0, oDone}, 32'd0, 0);
    chk("rstabort_k", oKmp1, 32'h0, 0);
    chk("rstabort_e", oErrormp1, 32'h0, 0);
    iReset  = 1'b1;
    iEnable = 1'b0;
    @(negedge clk);
    run_op(32'h3E80_0000, 32'h3F00_0000, 32'hBF00_0000, 32'h3EC0_0000, 0, 1'b0);
    drop_en(32'hBF00_0000, 32'h3EC0_0000, 0);

    // Drop iEnable mid-computation: no oDone may follow.
    @(negedge clk);
    iAlpham = 32'hBF00_0000;
    iErrorm = 32'h3F80_0000;
    iEnable = 1'b1;
    repeat (5) @(negedge clk);
    iEnable = 1'b0;
    repeat (40) @(negedge clk);
    chk("enabort_done", {31'd0, oDone}, 32'd0, 0);

    // Divide by zero: E = +0.
`ifdef CKAE_DIVZERO_FLAG_EN
    run_op(32'h3E99_999A, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 1'b1);
`else
    run_op(32'h3E99_999A, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 1'b0);
`endif
    drop_en(32'h0000_0000, 32'h0000_0000, 0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
